pq_op_scheduler: RTL and testbench
==================================

Name: pq_op_scheduler

Overview:
Front-end stage that sits directly upstream of the register-tree priority queue (max-heap, value 0 = empty slot). It buffers push requests in a small FIFO, accepts pop requests, and drives the queue's write/read strobes as enqueue, dequeue or replace operations. After every queue operation it inserts idle cycles so the tree's compare-and-swap maintenance can settle. It returns popped values on a registered response port and bypasses the tree when a buffered item beats the current root.

Parameters:
DATA_WIDTH, 16, width of keys; must match the downstream queue.
FIFO_DEPTH, 4, push buffer entries; power of 2, >= 2.
SETTLE_CYCLES, 2, idle cycles forced after each queue operation; >= 1.

Ports:
i_CLK  in  1  clock, all state on rising edge.
i_RST  in  1  synchronous reset, active-high.
i_push_valid  in  1  push request.
o_push_ready  out  1  FIFO not full.
i_push_data  in  DATA_WIDTH  push key.
i_pop_valid  in  1  pop request.
o_pop_ready  out  1  no pop currently pending.
o_pop_valid  out  1  one-cycle pulse, pop response valid.
o_pop_data  out  DATA_WIDTH  popped key; held until next response.
o_pq_wrt  out  1  queue write strobe.
o_pq_read  out  1  queue read strobe.
o_pq_data  out  DATA_WIDTH  data to queue; equals FIFO head.
i_pq_full  in  1  queue full flag.
i_pq_empty  in  1  queue empty flag.
i_pq_data  in  DATA_WIDTH  queue root (current max).
o_zero_drop  out  1  one-cycle pulse, a zero-valued push was discarded.
o_fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered push count.

Behaviour:
- Reset (i_RST high at clock edge): FIFO empty, pop_pending=0, settle counter=0. o_pop_valid=0, o_pop_data=0, o_zero_drop=0, o_pq_wrt=0, o_pq_read=0, o_push_ready=1, o_pop_ready=1, o_fifo_count=0. Reset mid-operation discards buffered pushes and the pending pop; no response is produced for them.
- Push handshake: accepted when i_push_valid && o_push_ready. A key of 0 is accepted but not stored, because 0 marks an empty slot in the queue. o_zero_drop pulses in the following cycle.
- Pop handshake: accepted when i_pop_valid && o_pop_ready. Acceptance sets pop_pending; only one pop may be outstanding.
- o_pq_wrt, o_pq_read and o_pq_data are decoded combinationally from registered state and the queue flags only; there is no path from i_push_* or i_pop_*. A push or pop accepted in cycle N can issue in cycle N+1 at the earliest.
- Issue is allowed only when the settle counter is 0. Decision in priority order:
  1. pop_pending, FIFO non-empty, and (i_pq_empty or head > i_pq_data): BYPASS. No strobes; pop the FIFO; response = head; settle counter untouched.
  2. pop_pending, FIFO non-empty, !i_pq_empty, head <= i_pq_data: REPLACE. wrt=1, read=1, o_pq_data=head; response = i_pq_data; pop the FIFO. Ties use REPLACE.
  3. pop_pending, FIFO empty, !i_pq_empty: DEQUEUE. read=1; response = i_pq_data.
  4. pop_pending, both empty: wait. pop_pending stays set and no enqueue is issued.
  5. !pop_pending, FIFO non-empty, !i_pq_full: ENQUEUE. wrt=1, o_pq_data=head; pop the FIFO.
  6. Otherwise: idle (strobes 0).
- An issued REPLACE, DEQUEUE or BYPASS clears pop_pending. o_pop_valid pulses and o_pop_data updates at the edge that ends the issue cycle, so both are visible one cycle after issue.
- Each REPLACE, DEQUEUE or ENQUEUE loads settle counter = SETTLE_CYCLES. The counter decrements each cycle to 0. Strobes are never high on consecutive cycles.
- If the queue is full and no pop is pending, pushes accumulate until the FIFO is full; then o_push_ready=0.
- A push and a pop in the same cycle: the FIFO write is visible the next cycle and takes part in that cycle's decision.
- FIFO pointers wrap modulo FIFO_DEPTH. o_fifo_count counts 0..FIFO_DEPTH. A FIFO read and write in the same cycle leaves the count unchanged.

Test Plan:
- Reset, then push 5 with queue empty and not full -> o_pq_wrt=1, o_pq_data=5 exactly one cycle after acceptance; no further strobe for 2 cycles; o_fifo_count returns to 0.
- Push 0 -> o_zero_drop pulses once; no strobe; o_fifo_count stays 0.
- Queue root 9 (not empty), FIFO empty, pop -> o_pq_read=1 alone; next cycle o_pop_valid=1, o_pop_data=9; o_pop_ready high again.
- Root 9, FIFO holds 4, pop -> REPLACE: wrt=1, read=1, o_pq_data=4, response 9. Repeat with FIFO holding 12 -> no strobes, response 12 (bypass).
- i_pq_full=1, push 1,2,3,4,5 back-to-back with FIFO_DEPTH=4 -> four accepted, o_push_ready=0 on the fifth; no o_pq_wrt while full. Deassert full -> four enqueues, each separated by 2 idle cycles.
- Pop pending with queue and FIFO both empty, reset asserted for one cycle -> no o_pop_valid; o_pop_ready=1 after reset.

Source files
------------

// File: rtl/pq_op_scheduler.sv
// Front-end scheduler for the register-tree max-heap priority queue.
// Buffers pushes in a small FIFO, tracks one outstanding pop, and turns them
// into enqueue / dequeue / replace strobes, with forced idle cycles after each
// tree operation so the compare-and-swap network can settle. A buffered key
// larger than the current root is returned directly without touching the tree.
module pq_op_scheduler #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic                          i_push_valid,
  output logic                          o_push_ready,
  input  logic [DATA_WIDTH-1:0]         i_push_data,
  input  logic                          i_pop_valid,
  output logic                          o_pop_ready,
  output logic                          o_pop_valid,
  output logic [DATA_WIDTH-1:0]         o_pop_data,
  output logic                          o_pq_wrt,
  output logic                          o_pq_read,
  output logic [DATA_WIDTH-1:0]         o_pq_data,
  input  logic                          i_pq_full,
  input  logic                          i_pq_empty,
  input  logic [DATA_WIDTH-1:0]         i_pq_data,
  output logic                          o_zero_drop,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CntW-1:0] FullCount  = CntW'(FIFO_DEPTH);
  localparam logic [SetW-1:0] SettleLoad = SetW'(SETTLE_CYCLES);

  typedef enum logic [2:0] {OpIdle, OpEnq, OpDeq, OpRep, OpByp} op_e;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [CntW-1:0]       r_count;
  logic                  r_pop_pending;
  logic [SetW-1:0]       r_settle;
  logic                  r_pop_valid;
  logic [DATA_WIDTH-1:0] r_pop_data;
  logic                  r_zero_drop;

  op_e                   w_op;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_push_acc;
  logic                  w_push_store;
  logic                  w_pop_acc;
  logic                  w_fifo_rd;
  logic                  w_pop_done;
  logic                  w_settle_load;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == FullCount);
  assign w_head       = r_mem[r_rd_ptr];

  assign o_push_ready = !w_fifo_full;
  assign o_pop_ready  = !r_pop_pending;

  assign w_push_acc   = i_push_valid && o_push_ready;
  // Zero marks an empty heap slot, so it is acknowledged but never buffered.
  assign w_push_store = w_push_acc && (i_push_data != '0);
  assign w_pop_acc    = i_pop_valid && o_pop_ready;

  // Operation decode: registered state and queue flags only, never the request inputs.
  always_comb begin
    w_op = OpIdle;
    if (r_settle == '0) begin
      if (r_pop_pending) begin
        if (!w_fifo_empty) begin
          // Ties go to the tree so equal keys keep their enqueue order there.
          if (i_pq_empty || (w_head > i_pq_data)) begin
            w_op = OpByp;
          end else begin
            w_op = OpRep;
          end
        end else if (!i_pq_empty) begin
          w_op = OpDeq;
        end
      end else if (!w_fifo_empty && !i_pq_full) begin
        w_op = OpEnq;
      end
    end
  end

  // Strobe and side-effect decode of the selected operation.
  always_comb begin
    o_pq_wrt      = (w_op == OpEnq) || (w_op == OpRep);
    o_pq_read     = (w_op == OpDeq) || (w_op == OpRep);
    o_pq_data     = w_head;
    w_fifo_rd     = (w_op == OpEnq) || (w_op == OpRep) || (w_op == OpByp);
    w_pop_done    = (w_op == OpDeq) || (w_op == OpRep) || (w_op == OpByp);
    // Bypass leaves the tree untouched, so it needs no settle time.
    w_settle_load = (w_op == OpEnq) || (w_op == OpRep) || (w_op == OpDeq);
  end

  // FIFO storage; contents are don't-care once pointers are reset.
  always_ff @(posedge i_CLK) begin
    if (w_push_store) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // FIFO pointers, occupancy, pending pop and settle counter.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_pop_pending <= 1'b0;
      r_settle      <= '0;
    end else begin
      if (w_push_store) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_fifo_rd) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_push_store) - CntW'(w_fifo_rd);
      if (w_pop_done) begin
        r_pop_pending <= 1'b0;
      end else if (w_pop_acc) begin
        r_pop_pending <= 1'b1;
      end
      if (w_settle_load) begin
        r_settle <= SettleLoad;
      end else if (r_settle != '0) begin
        r_settle <= r_settle - SetW'(1);
      end
    end
  end

  // Registered pop response and zero-drop pulse.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_pop_valid <= 1'b0;
      r_pop_data  <= '0;
      r_zero_drop <= 1'b0;
    end else begin
      r_pop_valid <= w_pop_done;
      if (w_pop_done) begin
        r_pop_data <= (w_op == OpByp) ? w_head : i_pq_data;
      end
      r_zero_drop <= w_push_acc && (i_push_data == '0);
    end
  end

  assign o_pop_valid  = r_pop_valid;
  assign o_pop_data   = r_pop_data;
  assign o_zero_drop  = r_zero_drop;
  assign o_fifo_count = r_count;

endmodule

// File: tb/tb_pq_op_scheduler.sv
// Self-checking bench for pq_op_scheduler: scenario tasks with inline checks,
// plus a negedge monitor scoring queue strobes and pop responses against
// expectation queues filled as stimulus is driven.
module tb_pq_op_scheduler;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          i_RST;
  logic          i_push_valid;
  logic          o_push_ready;
  logic [DW-1:0] i_push_data;
  logic          i_pop_valid;
  logic          o_pop_ready;
  logic          o_pop_valid;
  logic [DW-1:0] o_pop_data;
  logic          o_pq_wrt;
  logic          o_pq_read;
  logic [DW-1:0] o_pq_data;
  logic          i_pq_full;
  logic          i_pq_empty;
  logic [DW-1:0] i_pq_data;
  logic          o_zero_drop;
  logic [2:0]    o_fifo_count;

  always #5 clk = ~clk;

  pq_op_scheduler #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (4),
    .SETTLE_CYCLES(2)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (i_RST),
    .i_push_valid(i_push_valid),
    .o_push_ready(o_push_ready),
    .i_push_data (i_push_data),
    .i_pop_valid (i_pop_valid),
    .o_pop_ready (o_pop_ready),
    .o_pop_valid (o_pop_valid),
    .o_pop_data  (o_pop_data),
    .o_pq_wrt    (o_pq_wrt),
    .o_pq_read   (o_pq_read),
    .o_pq_data   (o_pq_data),
    .i_pq_full   (i_pq_full),
    .i_pq_empty  (i_pq_empty),
    .i_pq_data   (i_pq_data),
    .o_zero_drop (o_zero_drop),
    .o_fifo_count(o_fifo_count)
  );

  typedef struct packed {
    logic          wrt;
    logic          rd;
    logic [DW-1:0] data;
  } op_t;

  int            n_checks = 0;
  int            n_errors = 0;
  op_t           exp_ops[$];
  logic [DW-1:0] exp_resp[$];
  bit            mon_en = 1'b0;
  logic          prev_strobe = 1'b0;
  op_t           mon_op;
  logic [DW-1:0] mon_resp;

  // Scoreboard monitor: every strobe and every response must match the next expectation.
  always @(negedge clk) begin
    if (i_RST) begin
      prev_strobe = 1'b0;
    end else if (mon_en) begin
      if (o_pq_wrt || o_pq_read) begin
        n_checks++;
        if (prev_strobe) begin
          n_errors++;
          $display("FAIL strobe_gap: strobe at %0t follows a strobe, want an idle cycle", $time);
        end
        n_checks++;
        if (exp_ops.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_op: got wrt=%0b read=%0b data=%0d, want no operation",
                   o_pq_wrt, o_pq_read, o_pq_data);
        end else begin
          mon_op = exp_ops.pop_front();
          if (o_pq_wrt !== mon_op.wrt || o_pq_read !== mon_op.rd ||
              (mon_op.wrt && o_pq_data !== mon_op.data)) begin
            n_errors++;
            $display("FAIL sb_op: got wrt=%0b read=%0b data=%0d, want wrt=%0b read=%0b data=%0d",
                     o_pq_wrt, o_pq_read, o_pq_data, mon_op.wrt, mon_op.rd, mon_op.data);
          end
        end
      end
      prev_strobe = o_pq_wrt || o_pq_read;
      if (o_pop_valid) begin
        n_checks++;
        if (exp_resp.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_resp: got pop_data=%0d, want no response", o_pop_data);
        end else begin
          mon_resp = exp_resp.pop_front();
          if (o_pop_data !== mon_resp) begin
            n_errors++;
            $display("FAIL sb_resp: got pop_data=%0d, want %0d", o_pop_data, mon_resp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_RST = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_pop_valid !== 1'b0 || o_pop_data !== '0 || o_zero_drop !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_resp: got valid=%0b data=%0d zd=%0b, want 0 0 0",
               o_pop_valid, o_pop_data, o_zero_drop);
    end
    n_checks++;
    if (o_pq_wrt !== 1'b0 || o_pq_read !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_strobe: got wrt=%0b read=%0b, want 0 0", o_pq_wrt, o_pq_read);
    end
    n_checks++;
    if (o_push_ready !== 1'b1 || o_pop_ready !== 1'b1 || o_fifo_count !== 3'd0) begin
      n_errors++;
      $display("FAIL rst_ready: got push_rdy=%0b pop_rdy=%0b cnt=%0d, want 1 1 0",
               o_push_ready, o_pop_ready, o_fifo_count);
    end
    @(posedge clk);
    #1 i_RST = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_push_ready !== 1'b1 || o_pop_ready !== 1'b1 || o_pq_wrt !== 1'b0) begin
      n_errors++;
      $display("FAIL post_rst: got push_rdy=%0b pop_rdy=%0b wrt=%0b, want 1 1 0",
               o_push_ready, o_pop_ready, o_pq_wrt);
    end
  endtask

  task automatic test_enqueue();
    tick();
    i_push_valid = 1'b1;
    i_push_data  = DW'(5);
    exp_ops.push_back({1'b1, 1'b0, DW'(5)});
    @(negedge clk);
    n_checks++;
    if (o_pq_wrt !== 1'b0) begin
      n_errors++;
      $display("FAIL enq_no_comb: got wrt=%0b in accept cycle, want 0", o_pq_wrt);
    end
    tick();
    i_push_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_pq_wrt !== 1'b1 || o_pq_read !== 1'b0 || o_pq_data !== DW'(5)) begin
      n_errors++;
      $display("FAIL enq_issue: got wrt=%0b read=%0b data=%0d, want 1 0 5",
               o_pq_wrt, o_pq_read, o_pq_data);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_pq_wrt !== 1'b0 || o_pq_read !== 1'b0 || o_fifo_count !== 3'd0) begin
        n_errors++;
        $display("FAIL enq_settle%0d: got wrt=%0b read=%0b cnt=%0d, want 0 0 0",
                 i, o_pq_wrt, o_pq_read, o_fifo_count);
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zero_drop();
    tick();
    i_push_valid = 1'b1;
    i_push_data  = '0;
    @(negedge clk);
    n_checks++;
    if (o_zero_drop !== 1'b0) begin
      n_errors++;
      $display("FAIL zd_early: got zero_drop=%0b in accept cycle, want 0", o_zero_drop);
    end
    tick();
    i_push_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_zero_drop !== 1'b1 || o_fifo_count !== 3'd0 || o_pq_wrt !== 1'b0) begin
      n_errors++;
      $display("FAIL zd_pulse: got zd=%0b cnt=%0d wrt=%0b, want 1 0 0",
               o_zero_drop, o_fifo_count, o_pq_wrt);
    end
    @(negedge clk);
    n_checks++;
    if (o_zero_drop !== 1'b0 || o_fifo_count !== 3'd0) begin
      n_errors++;
      $display("FAIL zd_once: got zd=%0b cnt=%0d, want 0 0", o_zero_drop, o_fifo_count);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_dequeue();
    tick();
    i_pq_empty  = 1'b0;
    i_pq_data   = DW'(9);
    tick();
    i_pop_valid = 1'b1;
    exp_ops.push_back({1'b0, 1'b1, DW'(0)});
    exp_resp.push_back(DW'(9));
    @(negedge clk);
    n_checks++;
    if (o_pq_read !== 1'b0 || o_pop_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL deq_accept: got read=%0b pop_rdy=%0b, want 0 1", o_pq_read, o_pop_ready);
    end
    tick();
    i_pop_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_pq_read !== 1'b1 || o_pq_wrt !== 1'b0 || o_pop_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL deq_issue: got read=%0b wrt=%0b pop_rdy=%0b, want 1 0 0",
               o_pq_read, o_pq_wrt, o_pop_ready);
    end
    @(negedge clk);
    n_checks++;
    if (o_pop_valid !== 1'b1 || o_pop_data !== DW'(9) || o_pop_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL deq_resp: got valid=%0b data=%0d pop_rdy=%0b, want 1 9 1",
               o_pop_valid, o_pop_data, o_pop_ready);
    end
    @(negedge clk);
    n_checks++;
    if (o_pop_valid !== 1'b0 || o_pop_data !== DW'(9)) begin
      n_errors++;
      $display("FAIL deq_hold: got valid=%0b data=%0d, want 0 9", o_pop_valid, o_pop_data);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_replace_bypass();
    // Replace (4 < root 9), then a tie (9 == 9) which must also replace.
    for (int k = 0; k < 2; k++) begin
      tick();
      i_push_valid = 1'b1;
      i_push_data  = (k == 0) ? DW'(4) : DW'(9);
      i_pop_valid  = 1'b1;
      exp_ops.push_back({1'b1, 1'b1, i_push_data});
      exp_resp.push_back(DW'(9));
      tick();
      i_push_valid = 1'b0;
      i_pop_valid  = 1'b0;
      @(negedge clk);
      n_checks++;
      if (o_pq_wrt !== 1'b1 || o_pq_read !== 1'b1 || o_pq_data !== ((k == 0) ? DW'(4) : DW'(9)))
      begin
        n_errors++;
        $display("FAIL rep%0d_issue: got wrt=%0b read=%0b data=%0d, want 1 1 %0d",
                 k, o_pq_wrt, o_pq_read, o_pq_data, (k == 0) ? 4 : 9);
      end
      @(negedge clk);
      n_checks++;
      if (o_pop_valid !== 1'b1 || o_pop_data !== DW'(9) || o_fifo_count !== 3'd0) begin
        n_errors++;
        $display("FAIL rep%0d_resp: got valid=%0b data=%0d cnt=%0d, want 1 9 0",
                 k, o_pop_valid, o_pop_data, o_fifo_count);
      end
      repeat (3) @(posedge clk);
    end
    // Bypass 12 > 9, with a push of 7 landing on the same edge as the bypass read.
    tick();
    i_push_valid = 1'b1;
    i_push_data  = DW'(12);
    i_pop_valid  = 1'b1;
    exp_resp.push_back(DW'(12));
    tick();
    i_pop_valid = 1'b0;
    i_push_data = DW'(7);
    exp_ops.push_back({1'b1, 1'b0, DW'(7)});
    @(negedge clk);
    n_checks++;
    if (o_pq_wrt !== 1'b0 || o_pq_read !== 1'b0 || o_fifo_count !== 3'd1) begin
      n_errors++;
      $display("FAIL byp_issue: got wrt=%0b read=%0b cnt=%0d, want 0 0 1",
               o_pq_wrt, o_pq_read, o_fifo_count);
    end
    tick();
    i_push_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_pop_valid !== 1'b1 || o_pop_data !== DW'(12)) begin
      n_errors++;
      $display("FAIL byp_resp: got valid=%0b data=%0d, want 1 12", o_pop_valid, o_pop_data);
    end
    n_checks++;
    if (o_fifo_count !== 3'd1 || o_pq_wrt !== 1'b1 || o_pq_data !== DW'(7)) begin
      n_errors++;
      $display("FAIL byp_no_settle: got cnt=%0d wrt=%0b data=%0d, want 1 1 7",
               o_fifo_count, o_pq_wrt, o_pq_data);
    end
    @(negedge clk);
    n_checks++;
    if (o_fifo_count !== 3'd0) begin
      n_errors++;
      $display("FAIL byp_drain: got cnt=%0d, want 0", o_fifo_count);
    end
    repeat (3) @(posedge clk);
    // Empty tree: any buffered key bypasses, even one below the stale root value.
    tick();
    i_pq_empty   = 1'b1;
    i_push_valid = 1'b1;
    i_push_data  = DW'(3);
    i_pop_valid  = 1'b1;
    exp_resp.push_back(DW'(3));
    tick();
    i_push_valid = 1'b0;
    i_pop_valid  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_pq_wrt !== 1'b0 || o_pq_read !== 1'b0) begin
      n_errors++;
      $display("FAIL byp_empty_issue: got wrt=%0b read=%0b, want 0 0", o_pq_wrt, o_pq_read);
    end
    @(negedge clk);
    n_checks++;
    if (o_pop_valid !== 1'b1 || o_pop_data !== DW'(3)) begin
      n_errors++;
      $display("FAIL byp_empty_resp: got valid=%0b data=%0d, want 1 3", o_pop_valid, o_pop_data);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int n_wrt;
    tick();
    i_pq_full  = 1'b1;
    i_pq_empty = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      tick();
      n_checks++;
      if (o_push_ready !== (v < 5)) begin
        n_errors++;
        $display("FAIL b2b_ready%0d: got push_rdy=%0b, want %0b", v, o_push_ready, (v < 5));
      end
      i_push_valid = 1'b1;
      i_push_data  = DW'(v);
      if (v < 5) exp_ops.push_back({1'b1, 1'b0, DW'(v)});
    end
    tick();
    i_push_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_pq_wrt !== 1'b0 || o_fifo_count !== 3'd4) begin
        n_errors++;
        $display("FAIL b2b_hold%0d: got wrt=%0b cnt=%0d, want 0 4", i, o_pq_wrt, o_fifo_count);
      end
    end
    tick();
    i_pq_full = 1'b0;
    n_wrt = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (o_pq_wrt) begin
        n_checks++;
        if (c != 3 * n_wrt) begin
          n_errors++;
          $display("FAIL b2b_spacing: enqueue %0d at cycle %0d, want cycle %0d", n_wrt, c, 3 * n_wrt);
        end
        n_wrt++;
      end
    end
    n_checks++;
    if (n_wrt != 4 || o_fifo_count !== 3'd0) begin
      n_errors++;
      $display("FAIL b2b_drain: got %0d enqueues cnt=%0d, want 4 0", n_wrt, o_fifo_count);
    end
  endtask

  task automatic test_reset_pending();
    tick();
    i_pq_empty  = 1'b1;
    i_pop_valid = 1'b1;
    tick();
    i_pop_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_pop_ready !== 1'b0 || o_pq_read !== 1'b0 || o_pq_wrt !== 1'b0) begin
        n_errors++;
        $display("FAIL wait%0d: got pop_rdy=%0b read=%0b wrt=%0b, want 0 0 0",
                 i, o_pop_ready, o_pq_read, o_pq_wrt);
      end
    end
    tick();
    i_RST = 1'b1;
    tick();
    i_RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_pop_valid !== 1'b0 || o_pop_ready !== 1'b1 || o_pop_data !== '0) begin
        n_errors++;
        $display("FAIL rst_pend%0d: got valid=%0b pop_rdy=%0b data=%0d, want 0 1 0",
                 i, o_pop_valid, o_pop_ready, o_pop_data);
      end
    end
  endtask

  initial begin
    i_RST        = 1'b1;
    i_push_valid = 1'b0;
    i_push_data  = '0;
    i_pop_valid  = 1'b0;
    i_pq_full    = 1'b0;
    i_pq_empty   = 1'b1;
    i_pq_data    = '0;
    test_reset();
    mon_en = 1'b1;
    test_enqueue();
    test_zero_drop();
    test_dequeue();
    test_replace_bypass();
    test_back_to_back();
    test_reset_pending();
    n_checks++;
    if (exp_ops.size() != 0 || exp_resp.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: got %0d ops and %0d responses never seen, want 0 0",
               exp_ops.size(), exp_resp.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
